// File: rtl/bus_sequencer.sv
// rtl/bus_sequencer.sv - hardwired fetch/decode/execute sequencer for the single-bus datapath
// Optional single-step PAUSE state when SEQ_STEP_EN is defined.
module bus_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic        step,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic [31:0] bus_src,
    output logic [15:0] reg_in,
    output logic        HIin,
    output logic        LOin,
    output logic        Zhighin,
    output logic        Zlowin,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  alu_op,
    output logic        instr_done,
    output logic        halted,
    output logic        illegal
);

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] SRC_HI   = 5'd18;
    localparam logic [4:0] SRC_LO   = 5'd19;
    localparam logic [4:0] SRC_PC   = 5'd20;
    localparam logic [4:0] SRC_MDR  = 5'd21;
    localparam logic [4:0] SRC_CSGN = 5'd23;

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, E0, E1, E2, E3, E4, HALT
`ifdef SEQ_STEP_EN
        , PAUSE
`endif
    } state_t;

    state_t state, state_next, after_done;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_alu, is_md, is_ld, is_st, is_nop, is_halt, is_legal;
    logic       unused_ir;

    assign opcode = ir[31:27];
    assign ra     = ir[26:23];
    assign rb     = ir[22:19];
    assign rc     = ir[18:15];

    assign is_alu   = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHL};
    assign is_md    = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign is_ld    = (opcode == OP_LD);
    assign is_st    = (opcode == OP_ST);
    assign is_nop   = (opcode == OP_NOP);
    assign is_halt  = (opcode == OP_HALT);
    assign is_legal = is_alu | is_md | is_ld | is_st | is_nop | is_halt;

`ifdef SEQ_STEP_EN
    assign after_done = PAUSE;
    assign unused_ir  = ^ir[14:0];
`else
    assign after_done = T0;
    assign unused_ir  = ^{ir[14:0], step};
`endif

    function automatic logic [31:0] onehot(input logic [4:0] idx);
        return 32'd1 << idx;
    endfunction

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (run) state_next = T0;
            T0:   state_next = T1;
            T1:   state_next = T2;
            T2:   if (mem_ready) state_next = T3;
            T3:   state_next = E0;
            E0: begin
                if (is_halt)                 state_next = HALT;
                else if (is_nop | !is_legal) state_next = after_done;
                else                         state_next = E1;
            end
            E1:   state_next = E2;
            E2:   state_next = is_alu ? after_done : E3;
            E3: begin
                if (is_md)                   state_next = after_done;
                else if (!is_ld | mem_ready) state_next = E4;
            end
            E4:   if (is_ld | mem_ready) state_next = after_done;
            HALT: state_next = HALT;
`ifdef SEQ_STEP_EN
            PAUSE: if (step) state_next = T0;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus_src    = '0;
        reg_in     = '0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        Zhighin    = 1'b0;
        Zlowin     = 1'b0;
        PCin       = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        IncPC      = 1'b0;
        Read       = 1'b0;
        Write      = 1'b0;
        alu_op     = '0;
        instr_done = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;
        case (state)
            T0: begin
                bus_src = onehot(SRC_PC);
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zlowin  = 1'b1;
            end
            T1: begin
                bus_src = onehot(SRC_LO);
                PCin    = 1'b1;
            end
            T2: begin
                Read  = 1'b1;
                MDRin = mem_ready;
            end
            T3: begin
                bus_src = onehot(SRC_MDR);
                IRin    = 1'b1;
            end
            E0: begin
                if (is_alu | is_md | is_ld | is_st) begin
                    bus_src = onehot({1'b0, rb});
                    Yin     = 1'b1;
                end else begin
                    instr_done = 1'b1;
                    illegal    = !is_legal;
                end
            end
            E1: begin
                if (is_ld | is_st) begin
                    bus_src = onehot(SRC_CSGN);
                    alu_op  = OP_ADD;
                    Zlowin  = 1'b1;
                end else begin
                    bus_src = onehot({1'b0, rc});
                    alu_op  = opcode;
                    Zhighin = 1'b1;
                    Zlowin  = 1'b1;
                end
            end
            E2: begin
                bus_src = onehot(SRC_LO);
                if (is_alu) begin
                    reg_in     = 16'd1 << ra;
                    instr_done = 1'b1;
                end else if (is_md) begin
                    LOin = 1'b1;
                end else begin
                    MARin = 1'b1;
                end
            end
            E3: begin
                if (is_md) begin
                    bus_src    = onehot(SRC_HI);
                    HIin       = 1'b1;
                    instr_done = 1'b1;
                end else if (is_ld) begin
                    Read  = 1'b1;
                    MDRin = mem_ready;
                end else begin
                    bus_src = onehot({1'b0, ra});
                    MDRin   = 1'b1;
                end
            end
            E4: begin
                if (is_ld) begin
                    bus_src    = onehot(SRC_MDR);
                    reg_in     = 16'd1 << ra;
                    instr_done = 1'b1;
                end else begin
                    Write      = 1'b1;
                    instr_done = mem_ready;
                end
            end
            HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// tb/tb_bus_sequencer.sv - directed self-checking bench for bus_sequencer
// Covers the default build and, when SEQ_STEP_EN is defined, the PAUSE path.
module tb_bus_sequencer;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [31:0] ir = '0;
    logic        mem_ready = 1'b1;
    logic [31:0] bus_src;
    logic [15:0] reg_in;
    logic        HIin, LOin, Zhighin, Zlowin, PCin, MARin, MDRin, IRin, Yin, IncPC, Read, Write;
    logic [4:0]  alu_op;
    logic        instr_done, halted, illegal;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    localparam logic [14:0] S_HI   = 15'h4000;
    localparam logic [14:0] S_LO   = 15'h2000;
    localparam logic [14:0] S_ZH   = 15'h1000;
    localparam logic [14:0] S_ZL   = 15'h0800;
    localparam logic [14:0] S_PC   = 15'h0400;
    localparam logic [14:0] S_MAR  = 15'h0200;
    localparam logic [14:0] S_MDR  = 15'h0100;
    localparam logic [14:0] S_IR   = 15'h0080;
    localparam logic [14:0] S_Y    = 15'h0040;
    localparam logic [14:0] S_INC  = 15'h0020;
    localparam logic [14:0] S_RD   = 15'h0010;
    localparam logic [14:0] S_WR   = 15'h0008;
    localparam logic [14:0] S_DONE = 15'h0004;
    localparam logic [14:0] S_HLT  = 15'h0002;
    localparam logic [14:0] S_ILL  = 15'h0001;

    logic [14:0] strobes;
    assign strobes = {HIin, LOin, Zhighin, Zlowin, PCin, MARin, MDRin, IRin, Yin,
                      IncPC, Read, Write, instr_done, halted, illegal};

    bus_sequencer dut (
        .clk(clk), .clr(clr), .run(run), .step(step), .ir(ir), .mem_ready(mem_ready),
        .bus_src(bus_src), .reg_in(reg_in), .HIin(HIin), .LOin(LOin), .Zhighin(Zhighin),
        .Zlowin(Zlowin), .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .IncPC(IncPC), .Read(Read), .Write(Write), .alu_op(alu_op), .instr_done(instr_done),
        .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Check the current cycle's outputs, then advance one clock.
    task automatic cyc(input string tag, input logic [31:0] eb, input logic [14:0] es,
                       input logic [15:0] er, input logic [4:0] eo);
        #1;
        n++;
        check({tag, ".bus"}, bus_src, eb);
        check({tag, ".stb"}, {17'd0, strobes}, {17'd0, es});
        check({tag, ".reg"}, {16'd0, reg_in}, {16'd0, er});
        check({tag, ".op"}, {27'd0, alu_op}, {27'd0, eo});
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c, 15'd0};
    endfunction

    task automatic fetch(input string tag);
        cyc({tag, ".t0"}, 32'h0010_0000, S_MAR | S_INC | S_ZL, 16'h0, 5'd0);
        cyc({tag, ".t1"}, 32'h0008_0000, S_PC, 16'h0, 5'd0);
        cyc({tag, ".t2"}, 32'h0, S_RD | S_MDR, 16'h0, 5'd0);
        cyc({tag, ".t3"}, 32'h0020_0000, S_IR, 16'h0, 5'd0);
    endtask

    task automatic after_done(input string tag);
`ifdef SEQ_STEP_EN
        for (int i = 0; i < 10; i++) cyc({tag, ".pause"}, 32'h0, 15'h0, 16'h0, 5'd0);
        step = 1'b1;
        cyc({tag, ".pstep"}, 32'h0, 15'h0, 16'h0, 5'd0);
        step = 1'b0;
`else
        step = 1'b1;
`endif
    endtask

    initial begin
        #2 clr = 1'b1;
        cyc("rst", 32'h0, 15'h0, 16'h0, 5'd0);
        clr = 1'b0;
        run = 1'b1;
        cyc("idle_run", 32'h0, 15'h0, 16'h0, 5'd0);
        run = 1'b0;
        cyc("t0a", 32'h0010_0000, S_MAR | S_INC | S_ZL, 16'h0, 5'd0);
        cyc("t1a", 32'h0008_0000, S_PC, 16'h0, 5'd0);
        mem_ready = 1'b0;
        cyc("t2wait", 32'h0, S_RD, 16'h0, 5'd0);
        clr = 1'b1;
        cyc("clr_mid", 32'h0, 15'h0, 16'h0, 5'd0);
        clr = 1'b0;
        mem_ready = 1'b1;
        cyc("idle_hold", 32'h0, 15'h0, 16'h0, 5'd0);
        run = 1'b1;
        ir  = 32'h1989_0000;
        cyc("idle_go", 32'h0, 15'h0, 16'h0, 5'd0);

        // add r3,r1,r2 with run left high, which must be ignored
        n = 0;
        fetch("add");
        cyc("add.e0", 32'h2, S_Y, 16'h0, 5'd0);
        cyc("add.e1", 32'h4, S_ZH | S_ZL, 16'h0, 5'b00011);
        cyc("add.e2", 32'h0008_0000, S_DONE, 16'h0008, 5'd0);
        check("add.lat", n, 7);
        after_done("add");
        step = 1'b0;

        // ld r4 with three wait cycles in E3
        ir = mk(5'b00000, 4'd4, 4'd2, 4'd0);
        n = 0;
        fetch("ld");
        cyc("ld.e0", 32'h4, S_Y, 16'h0, 5'd0);
        cyc("ld.e1", 32'h0080_0000, S_ZL, 16'h0, 5'b00011);
        cyc("ld.e2", 32'h0008_0000, S_MAR, 16'h0, 5'd0);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("ld.e3w", 32'h0, S_RD, 16'h0, 5'd0);
        mem_ready = 1'b1;
        cyc("ld.e3", 32'h0, S_RD | S_MDR, 16'h0, 5'd0);
        cyc("ld.e4", 32'h0020_0000, S_DONE, 16'h0010, 5'd0);
        check("ld.lat", n, 12);
        after_done("ld");
        step = 1'b0;

        // st r5 with two wait cycles in E4
        ir = mk(5'b00010, 4'd5, 4'd1, 4'd0);
        n = 0;
        fetch("st");
        cyc("st.e0", 32'h2, S_Y, 16'h0, 5'd0);
        cyc("st.e1", 32'h0080_0000, S_ZL, 16'h0, 5'b00011);
        cyc("st.e2", 32'h0008_0000, S_MAR, 16'h0, 5'd0);
        cyc("st.e3", 32'h20, S_MDR, 16'h0, 5'd0);
        mem_ready = 1'b0;
        cyc("st.e4w", 32'h0, S_WR, 16'h0, 5'd0);
        cyc("st.e4w", 32'h0, S_WR, 16'h0, 5'd0);
        mem_ready = 1'b1;
        cyc("st.e4", 32'h0, S_WR | S_DONE, 16'h0, 5'd0);
        check("st.lat", n, 11);
        after_done("st");
        step = 1'b0;

        // mul r0,r6,r7
        ir = mk(5'b01111, 4'd0, 4'd6, 4'd7);
        n = 0;
        fetch("mul");
        cyc("mul.e0", 32'h40, S_Y, 16'h0, 5'd0);
        cyc("mul.e1", 32'h80, S_ZH | S_ZL, 16'h0, 5'b01111);
        cyc("mul.e2", 32'h0008_0000, S_LO, 16'h0, 5'd0);
        cyc("mul.e3", 32'h0004_0000, S_HI | S_DONE, 16'h0, 5'd0);
        check("mul.lat", n, 8);
        after_done("mul");
        step = 1'b0;

        // undefined opcode 11111, then 01010 which sits inside the ALU range
        ir = mk(5'b11111, 4'd1, 4'd1, 4'd1);
        fetch("ill");
        cyc("ill.e0", 32'h0, S_DONE | S_ILL, 16'h0, 5'd0);
        after_done("ill");
        step = 1'b0;
        ir = mk(5'b01010, 4'd1, 4'd1, 4'd1);
        fetch("ill2");
        cyc("ill2.e0", 32'h0, S_DONE | S_ILL, 16'h0, 5'd0);
        after_done("ill2");
        step = 1'b0;

        // two nops back to back
        ir = mk(5'b11010, 4'd0, 4'd0, 4'd0);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            fetch("nop");
            cyc("nop.e0", 32'h0, S_DONE, 16'h0, 5'd0);
            check("nop.lat", n, 5);
            after_done("nop");
            step = 1'b0;
        end

        // halt, stays halted until clr
        ir = mk(5'b11011, 4'd0, 4'd0, 4'd0);
        fetch("halt");
        cyc("halt.e0", 32'h0, S_DONE, 16'h0, 5'd0);
        step = 1'b1;
        for (int i = 0; i < 3; i++) cyc("halt.hold", 32'h0, S_HLT, 16'h0, 5'd0);
        step = 1'b0;
        clr = 1'b1;
        run = 1'b0;
        cyc("halt.clr", 32'h0, 15'h0, 16'h0, 5'd0);
        clr = 1'b0;
        cyc("halt.idle", 32'h0, 15'h0, 16'h0, 5'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
